l1_write_buffer: RTL and testbench

Single-entry write-back buffer sitting directly downstream of the L1D cache controller. It captures one evicted dirty 8-word block while the controller holds `write_l2` high, returns `wb_ack` on the final word so the controller can proceed to its L2 refill, then drains the block to L2 one word per handshake. A read-snoop port, when compiled in, forwards data for addresses still held in the buffer.

---
 rtl/l1_write_buffer_if.sv | 35 +++
 rtl/l1_write_buffer.sv | 102 ++++++++++
 tb/tb_l1_write_buffer.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/l1_write_buffer_if.sv
// L1D -> L2 write-back buffer bus: fill, drain and snoop signals.
// master = cache controller / L2 side, slave = l1_write_buffer.
interface l1_write_buffer_if #(
  parameter int WORD_W = 32,
  parameter int ADDR_W = 32
);
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [WORD_W-1:0] wr_data;
  logic              wb_ack;
  logic              wb_full;
  logic              l2_wr_valid;
  logic              l2_wr_ready;
  logic [ADDR_W-1:0] l2_wr_addr;
  logic [WORD_W-1:0] l2_wr_data;
  logic [ADDR_W-1:0] snoop_addr;
  logic              snoop_hit;
  logic [WORD_W-1:0] snoop_data;

  modport master (
    output wr_req, wr_addr, wr_data,
    output l2_wr_ready, snoop_addr,
    input  wb_ack, wb_full,
    input  l2_wr_valid, l2_wr_addr, l2_wr_data,
    input  snoop_hit, snoop_data
  );

  modport slave (
    input  wr_req, wr_addr, wr_data,
    input  l2_wr_ready, snoop_addr,
    output wb_ack, wb_full,
    output l2_wr_valid, l2_wr_addr, l2_wr_data,
    output snoop_hit, snoop_data
  );
endinterface

// File: rtl/l1_write_buffer.sv
// Single-entry write-back buffer: captures one evicted block, drains it to L2.
// Optional read-snoop forwarding is built when L1_WB_FORWARD_EN is defined.
module l1_write_buffer #(
  parameter int WORD_W      = 32,
  parameter int BLOCK_WORDS = 8,
  parameter int ADDR_W      = 32
) (
  input logic               clk,
  input logic               reset_n,
  l1_write_buffer_if.slave  wb
);
  localparam int IDX_W = $clog2(BLOCK_WORDS);
  localparam int OFF_W = IDX_W + 2;
  localparam int TAG_W = ADDR_W - OFF_W;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(BLOCK_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_DRAIN
  } state_t;

  state_t            r_state;
  logic [IDX_W-1:0]  r_fcnt;
  logic [IDX_W-1:0]  r_dcnt;
  logic [TAG_W-1:0]  r_tag;
  logic [WORD_W-1:0] r_mem [BLOCK_WORDS];

  logic w_store;
  logic w_last_fill;
  logic w_beat;

  // Fill words land at r_fcnt, which is 0 whenever the buffer is idle.
  assign w_store = wb.wr_req &&
                   (r_state == S_IDLE || r_state == S_FILL);
  assign w_last_fill = (r_state == S_FILL) && wb.wr_req &&
                       (r_fcnt == LAST);
  assign w_beat = (r_state == S_DRAIN) && wb.l2_wr_ready;

  assign wb.wb_ack      = w_last_fill;
  assign wb.wb_full     = (r_state == S_DRAIN);
  assign wb.l2_wr_valid = (r_state == S_DRAIN);
  assign wb.l2_wr_addr  = {r_tag, r_dcnt, 2'b00};
  assign wb.l2_wr_data  = r_mem[r_dcnt];

  // Control FSM: idle -> fill 8 words -> drain 8 beats -> idle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_fcnt  <= '0;
      r_dcnt  <= '0;
      r_tag   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (wb.wr_req) begin
            r_tag   <= wb.wr_addr[ADDR_W-1:OFF_W];
            r_fcnt  <= IDX_W'(1);
            r_state <= S_FILL;
          end
        end
        S_FILL: begin
          if (wb.wr_req) begin
            r_fcnt <= r_fcnt + 1'b1;
            if (r_fcnt == LAST) begin
              r_dcnt  <= '0;
              r_state <= S_DRAIN;
            end
          end else begin
            r_fcnt  <= '0;
            r_dcnt  <= '0;
            r_state <= S_IDLE;
          end
        end
        S_DRAIN: begin
          if (w_beat) begin
            r_dcnt <= r_dcnt + 1'b1;
            if (r_dcnt == LAST) r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Block storage; deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (reset_n && w_store) r_mem[r_fcnt] <= wb.wr_data;
  end

`ifdef L1_WB_FORWARD_EN
  logic w_hit;
  assign w_hit = (r_state == S_DRAIN) &&
                 (wb.snoop_addr[ADDR_W-1:OFF_W] == r_tag);
  assign wb.snoop_hit  = w_hit;
  assign wb.snoop_data = w_hit ?
                         r_mem[wb.snoop_addr[OFF_W-1:2]] : '0;
`else
  assign wb.snoop_hit  = 1'b0;
  assign wb.snoop_data = '0;
`endif
endmodule

// File: tb/tb_l1_write_buffer.sv
// Directed self-checking bench for l1_write_buffer.
// Inputs change 1ns after the rising edge; outputs are checked 1ns later.
module tb_l1_write_buffer;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_err = 0;
  int   n_chk = 0;

  always #5 clk = ~clk;

  l1_write_buffer_if #(.WORD_W(32), .ADDR_W(32)) bus ();

  l1_write_buffer #(
    .WORD_W(32), .BLOCK_WORDS(8), .ADDR_W(32)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .wb(bus.slave)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".ack"},   32'(bus.wb_ack), 32'd0);
    chk({tag, ".full"},  32'(bus.wb_full), 32'd0);
    chk({tag, ".valid"}, 32'(bus.l2_wr_valid), 32'd0);
  endtask

  task automatic snoop_chk(input string tag,
                           input logic [31:0] a,
                           input logic hit_on,
                           input logic [31:0] d_on);
    bus.snoop_addr = a;
    #1;
`ifdef L1_WB_FORWARD_EN
    chk({tag, ".hit"},  32'(bus.snoop_hit), 32'(hit_on));
    chk({tag, ".data"}, bus.snoop_data, hit_on ? d_on : 32'd0);
`else
    chk({tag, ".hit"},  32'(bus.snoop_hit), 32'd0);
    chk({tag, ".data"}, bus.snoop_data, 32'd0);
`endif
  endtask

  initial begin
    logic [31:0] base;
    int eb;
    bus.wr_req = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.l2_wr_ready = 1'b0;
    bus.snoop_addr = '0;

    // Reset
    step(); step();
    reset_n = 1'b1;
    #1;
    chk_idle("rst");
    chk("rst.addr", bus.l2_wr_addr, 32'd0);
    chk("rst.shit", 32'(bus.snoop_hit), 32'd0);
    chk("rst.sdata", bus.snoop_data, 32'd0);

    // Basic fill of block 0x1A40, ack only on word 8
    for (int i = 0; i < 8; i++) begin
      bus.wr_req = 1'b1;
      bus.wr_addr = 32'h0000_1A40;
      bus.wr_data = 32'h100 + i;
      #1;
      chk($sformatf("f1.ack%0d", i), 32'(bus.wb_ack),
          (i == 7) ? 32'd1 : 32'd0);
      chk($sformatf("f1.val%0d", i), 32'(bus.l2_wr_valid), 32'd0);
      snoop_chk($sformatf("f1.sn%0d", i), 32'h0000_1A40, 1'b0, 32'd0);
      step();
    end
    bus.wr_req = 1'b0;

    // Drain with ready tied high, snoop during drain
    bus.l2_wr_ready = 1'b1;
    for (int b = 0; b < 8; b++) begin
      #1;
      chk($sformatf("d1.val%0d", b), 32'(bus.l2_wr_valid), 32'd1);
      chk($sformatf("d1.full%0d", b), 32'(bus.wb_full), 32'd1);
      chk($sformatf("d1.addr%0d", b), bus.l2_wr_addr,
          32'h0000_1A40 + 4 * b);
      chk($sformatf("d1.data%0d", b), bus.l2_wr_data, 32'h100 + b);
      if (b == 3) begin
        snoop_chk("d1.snhit", 32'h0000_1A4C, 1'b1, 32'h103);
        snoop_chk("d1.snmiss", 32'h0000_1A60, 1'b0, 32'd0);
      end
      step();
    end
    bus.l2_wr_ready = 1'b0;
    #1;
    chk_idle("d1.end");
    snoop_chk("d1.snpost", 32'h0000_1A4C, 1'b0, 32'd0);

    // Fill 0x3000, drain with ready pattern 1,0,0,1,0,0...
    base = 32'h0000_3000;
    for (int i = 0; i < 8; i++) begin
      bus.wr_req = 1'b1;
      bus.wr_addr = base;
      bus.wr_data = 32'h200 + i;
      #1;
      chk($sformatf("f2.ack%0d", i), 32'(bus.wb_ack),
          (i == 7) ? 32'd1 : 32'd0);
      step();
    end
    bus.wr_req = 1'b0;
    eb = 0;
    for (int k = 0; k < 22; k++) begin
      bus.l2_wr_ready = (k % 3 == 0);
      #1;
      chk($sformatf("d2.val%0d", k), 32'(bus.l2_wr_valid), 32'd1);
      chk($sformatf("d2.addr%0d", k), bus.l2_wr_addr, base + 4 * eb);
      chk($sformatf("d2.data%0d", k), bus.l2_wr_data, 32'h200 + eb);
      if (k % 3 == 0) eb++;
      step();
    end
    bus.l2_wr_ready = 1'b0;
    #1;
    chk_idle("d2.end");
    step(); #1;
    chk_idle("d2.end2");

    // Aborted fill after 5 words
    for (int i = 0; i < 5; i++) begin
      bus.wr_req = 1'b1;
      bus.wr_addr = 32'h0000_5000;
      bus.wr_data = 32'h300 + i;
      #1;
      chk($sformatf("ab.ack%0d", i), 32'(bus.wb_ack), 32'd0);
      step();
    end
    bus.wr_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_idle($sformatf("ab.idle%0d", i));
      step();
    end

    // Fresh fill 0x6000 after abort
    for (int i = 0; i < 8; i++) begin
      bus.wr_req = 1'b1;
      bus.wr_addr = 32'h0000_6000;
      bus.wr_data = 32'h400 + i;
      #1;
      chk($sformatf("f3.ack%0d", i), 32'(bus.wb_ack),
          (i == 7) ? 32'd1 : 32'd0);
      step();
    end

    // Drain while the controller keeps wr_req high with a new block
    bus.wr_addr = 32'h0000_7000;
    bus.wr_data = 32'hDEAD_BEEF;
    bus.l2_wr_ready = 1'b1;
    for (int b = 0; b < 8; b++) begin
      #1;
      chk($sformatf("d3.ack%0d", b), 32'(bus.wb_ack), 32'd0);
      chk($sformatf("d3.full%0d", b), 32'(bus.wb_full), 32'd1);
      chk($sformatf("d3.addr%0d", b), bus.l2_wr_addr,
          32'h0000_6000 + 4 * b);
      chk($sformatf("d3.data%0d", b), bus.l2_wr_data, 32'h400 + b);
      step();
    end
    bus.l2_wr_ready = 1'b0;

    // New fill starts right after the last beat
    for (int i = 0; i < 8; i++) begin
      bus.wr_data = 32'h600 + i;
      #1;
      chk($sformatf("f4.ack%0d", i), 32'(bus.wb_ack),
          (i == 7) ? 32'd1 : 32'd0);
      chk($sformatf("f4.full%0d", i), 32'(bus.wb_full), 32'd0);
      step();
    end
    bus.wr_req = 1'b0;

    // Drain, reset asserted at beat 3
    bus.l2_wr_ready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      #1;
      chk($sformatf("d4.addr%0d", b), bus.l2_wr_addr,
          32'h0000_7000 + 4 * b);
      chk($sformatf("d4.data%0d", b), bus.l2_wr_data, 32'h600 + b);
      if (b == 3) reset_n = 1'b0;
      step();
    end
    reset_n = 1'b1;
    #1;
    chk_idle("mr");
    chk("mr.addr", bus.l2_wr_addr, 32'd0);
    snoop_chk("mr.sn", 32'h0000_700C, 1'b0, 32'd0);
    step(); #1;
    chk_idle("mr2");
    step(); #1;
    chk_idle("mr3");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
